// File: rtl/dmem_port_arbiter.sv
// Single-port data-memory arbiter: the pipeline M-stage has priority, and a
// starvation counter periodically forces a grant to the external load/debug port.
module dmem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          ext_valid,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ready,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic [CW-1:0] conflict_cnt
);

    localparam logic [3:0]    STARVE_LIMIT = 4'(STARVE_MAX);
    localparam logic [CW-1:0] CONFLICT_SAT = {CW{1'b1}};

    logic [3:0] starve_cnt;
    logic       ext_rd_pend;
    logic       ext_grant;
    logic       contended;

    // NOTE: every signal driven here is assigned a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        ext_grant = 1'b0;
        contended = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;

        contended = cpu_req & ext_valid;
        ext_grant = ext_valid & (~cpu_req | (starve_cnt == STARVE_LIMIT));

        if (ext_grant) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_we    = ext_we;
        end else begin
            mem_we    = cpu_req & cpu_we;
        end

        // Keep a write strobe from reaching the memory while reset is held.
        if (!rst) begin
            mem_we = 1'b0;
        end
    end

    assign ext_ready  = ext_grant;
    assign cpu_stall  = cpu_req & ext_grant;
    assign cpu_rdata  = mem_rdata;
    assign ext_rvalid = ext_rd_pend;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (ext_grant || !ext_valid) begin
            starve_cnt <= '0;
        end else if (starve_cnt < STARVE_LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Read response: capture combinational memory data during the grant cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_rd_pend <= 1'b0;
            ext_rdata   <= '0;
        end else begin
            ext_rd_pend <= ext_grant & ~ext_we;
            if (ext_grant && !ext_we) begin
                ext_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (contended && (conflict_cnt != CONFLICT_SAT)) begin
            conflict_cnt <= conflict_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench: a cycle-level reference model predicts grants, memory
// traffic and read responses for two arbiter configurations sharing stimulus.
module tb_dmem_port_arbiter;

    localparam int SMAX_A = 3;
    localparam int SMAX_B = 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        ext_valid = 1'b0, ext_we = 1'b0;
    logic [31:0] ext_addr = '0, ext_wdata = '0;

    logic [31:0] a_cpu_rdata, a_ext_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_cpu_stall, a_ext_ready, a_ext_rvalid, a_mem_we;
    logic [15:0] a_conflict;

    logic [31:0] b_cpu_rdata, b_ext_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_cpu_stall, b_ext_ready, b_ext_rvalid, b_mem_we;
    logic [3:0]  b_conflict;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    rsp_t        rsp_q [$];
    int          lost_a, lost_b, conf_a, conf_b, cyc;
    logic        last_g;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SMAX_A), .CW(16)) dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
        .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ready(a_ext_ready), .ext_rvalid(a_ext_rvalid), .ext_rdata(a_ext_rdata),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .conflict_cnt(a_conflict)
    );

    dmem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SMAX_B), .CW(4)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ready(b_ext_ready), .ext_rvalid(b_ext_rvalid), .ext_rdata(b_ext_rdata),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .conflict_cnt(b_conflict)
    );

    // Data_Memory model: combinational read, write at the rising edge.
    assign a_mem_rdata = mem[a_mem_addr[7:0]];
    assign b_mem_rdata = 32'h0;
    always @(posedge clk) if (a_mem_we) mem[a_mem_addr[7:0]] <= a_mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        lost_a = 0;
        lost_b = 0;
        conf_a = 0;
        conf_b = 0;
        rsp_q.delete();
    endtask

    // Inputs are driven just after a rising edge; this checks the combinational
    // response, advances the model and checks registered outputs after the edge.
    task automatic step();
        logic        ga, gb, we_e;
        logic [31:0] addr_e, wd_e;
        #2;
        ga     = ext_valid && (!cpu_req || lost_a == SMAX_A);
        gb     = ext_valid && (!cpu_req || lost_b == SMAX_B);
        addr_e = ga ? ext_addr : cpu_addr;
        wd_e   = ga ? ext_wdata : cpu_wdata;
        we_e   = rst && (ga ? ext_we : (cpu_req && cpu_we));
        check("a_ext_ready", 32'(a_ext_ready), 32'(ga));
        check("a_cpu_stall", 32'(a_cpu_stall), 32'(cpu_req && ga));
        check("a_mem_we", 32'(a_mem_we), 32'(we_e));
        check("a_mem_addr", a_mem_addr, addr_e);
        check("a_mem_wdata", a_mem_wdata, wd_e);
        if (cpu_req && !ga && !cpu_we)
            check("a_cpu_rdata", a_cpu_rdata, ref_mem[cpu_addr[7:0]]);
        check("b_ext_ready", 32'(b_ext_ready), 32'(gb));
        check("b_cpu_stall", 32'(b_cpu_stall), 32'(cpu_req && gb));
        if (rst) begin
            if (ga && !ext_we) rsp_q.push_back('{data: ref_mem[ext_addr[7:0]], cyc: cyc});
            if (we_e) ref_mem[addr_e[7:0]] = wd_e;
            lost_a = (ga || !ext_valid) ? 0 : lost_a + 1;
            lost_b = (gb || !ext_valid) ? 0 : lost_b + 1;
            if (cpu_req && ext_valid) begin
                if (conf_a < 65535) conf_a++;
                if (conf_b < 15) conf_b++;
            end
        end
        last_g = ga;
        @(posedge clk);
        #1;
        cyc++;
        check("a_conflict_cnt", 32'(a_conflict), conf_a);
        check("b_conflict_cnt", 32'(b_conflict), conf_b);
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic drive_ext(input logic v, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd);
        ext_valid = v; ext_we = we; ext_addr = addr; ext_wdata = wd;
    endtask

    // The external master keeps an ungranted request stable, apart from the
    // occasional abandonment.
    task automatic rand_inputs();
        drive_cpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 63)), $urandom);
        if (!(ext_valid && !last_g) || $urandom_range(0, 7) == 0)
            drive_ext($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 63)), $urandom);
    endtask

    // Response monitor: each read grant owes exactly one rvalid pulse one cycle later.
    always @(negedge clk) begin : monitor
        logic ev;
        ev = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc - 1);
        check("a_ext_rvalid", 32'(a_ext_rvalid), 32'(ev));
        if (ev) begin
            check("a_ext_rdata", a_ext_rdata, rsp_q[0].data);
            void'(rsp_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        cyc    = 0;
        last_g = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        reset_model();

        // Reset held with a CPU store and an external write presented.
        drive_cpu(1'b1, 1'b1, 32'h05, 32'h0000_0BAD);
        drive_ext(1'b1, 1'b1, 32'h06, 32'h0000_0BAD);
        @(posedge clk);
        #1;
        step();
        check("rst_ext_rvalid", 32'(a_ext_rvalid), 32'h0);
        check("rst_ext_rdata", a_ext_rdata, 32'h0);
        check("rst_no_write", mem[5], 32'h0);
        rst = 1'b1;

        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        drive_cpu(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        step();
        check("store_0x10", mem[16], 32'hDEAD_BEEF);

        // Idle CPU, external read of 0x10.
        drive_cpu(1'b0, 1'b0, 32'h10, 32'h0);
        drive_ext(1'b1, 1'b0, 32'h10, 32'h0);
        step();
        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("ext_rd_0x10", a_ext_rdata, 32'hDEAD_BEEF);

        // Sustained contention: external write wins on the fourth cycle, and the
        // CPU store presented in that cycle lands one cycle later.
        drive_ext(1'b1, 1'b1, 32'h20, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            drive_cpu(1'b1, 1'b0, 32'h10, 32'h0);
            step();
        end
        drive_cpu(1'b1, 1'b1, 32'h30, 32'hCAFE_0030);
        step();
        check("starve_wr_0x20", mem[32], 32'h1234_5678);
        check("stalled_store_held", mem[48], 32'h0);
        check("starve_conflicts", 32'(a_conflict), 32'd4);
        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("stalled_store_done", mem[48], 32'hCAFE_0030);

        // Abandoned read, then a fresh request must wait the full starvation window.
        drive_cpu(1'b1, 1'b0, 32'h20, 32'h0);
        drive_ext(1'b1, 1'b0, 32'h30, 32'h0);
        step();
        step();
        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        drive_ext(1'b1, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) step();
        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            step();
        end

        // Reset between the read grant and its response drops the response.
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drive_ext(1'b1, 1'b0, 32'h20, 32'h0);
        step();
        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        reset_model();
        step();
        check("midread_rvalid", 32'(a_ext_rvalid), 32'h0);
        check("midread_rdata", a_ext_rdata, 32'h0);
        rst = 1'b1;

        // Twenty contended cycles saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            drive_cpu(1'b1, 1'b0, 32'h10, 32'h0);
            drive_ext(1'b1, 1'b1, 32'h40 + 32'(i % 4), 32'h5A00_0000 + 32'(i));
            step();
        end
        check("conflict_sat", 32'(b_conflict), 32'd15);
        check("conflict_20", 32'(a_conflict), 32'd20);

        for (int i = 0; i < 1000; i++) begin
            rand_inputs();
            step();
        end

        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step();
        check("rsp_outstanding", 32'(rsp_q.size()), 32'h0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_image", 32'(bad), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
